mqnic_l2_ingress: RTL and testbench
===================================

// Module: mqnic_l2_ingress
// PURPOSE
//  Layer-2 ingress stage: receive-side counterpart of the egress MAC control frame (MCF) transmitter.
//  Passes the RX AXI stream through one register stage and parses the first 16+MCF_PARAMS_SIZE bytes.
//  Frames with EtherType == ETHERTYPE are MCFs: their fields go out on the mcf_* interface, and the
//  frame is marked bad (tuser[0]=1 on tlast) so the downstream RX FIFO drops it.
// PARAMETERS
//  AXIS_DATA_WIDTH  256                 stream width in bits; legal values 64, 128, 256, 512
//  AXIS_KEEP_WIDTH  AXIS_DATA_WIDTH/8   tkeep width
//  AXIS_USER_WIDTH  1                   tuser width; bit 0 = bad frame
//  MCF_PARAMS_SIZE  18                  MCF parameter bytes following the opcode
//  ETHERTYPE        16'h8808            MAC control EtherType
//  MCAST_DST        48'h0180C2000001    reserved MAC-control multicast DA
// PORTS
//  clk                           in   1     clock
//  rst_n                         in   1     synchronous active-low reset
//  s_axis_tdata/tkeep/tvalid/tlast/tuser  in  AXIS_*  RX stream from MAC
//  s_axis_tready                 out  1     input ready
//  m_axis_tdata/tkeep/tvalid/tlast/tuser  out AXIS_*  RX stream to datapath
//  m_axis_tready                 in   1     output ready
//  mcf_valid                     out  1     parsed MCF available
//  mcf_ready                     in   1     consumer accepts MCF
//  mcf_eth_dst / mcf_eth_src     out  48    DA / SA; [47:40] = first byte on the wire
//  mcf_eth_type / mcf_opcode     out  16    {byte12,byte13} / {byte14,byte15}
//  mcf_params                    out  MCF_PARAMS_SIZE*8  [7:0] = byte16 (lane order, as on TX)
//  cfg_rx_mcf_enable             in   1     0: no MCF parsing or marking; pure pass-through
//  cfg_rx_eth_dst_ucast          in   48    station unicast DA also accepted
//  cfg_rx_check_eth_dst          in   1     1: DA must equal MCAST_DST or cfg_rx_eth_dst_ucast
//  stat_rx_mcf                   out  1     1-cycle pulse when an MCF is presented
//  stat_rx_mcf_overrun           out  1     1-cycle pulse when a valid MCF is discarded
// BEHAVIOUR
//  Reset (rst_n=0 at edge): m_axis_tvalid=0, mcf_valid=0, stats=0, mcf_* fields=0, byte offset=0.
//    Reset is allowed mid-frame; the first beat accepted afterwards is treated as byte 0.
//  Stream: single output register; s_axis_tready = m_axis_tready | ~m_axis_tvalid; latency 1 cycle.
//    tdata/tkeep/tlast are copied unchanged. tuser is copied, except tuser[0] is OR'ed with mcf_hit on the tlast beat.
//  Byte offset: starts at 0 and advances by AXIS_KEEP_WIDTH per accepted non-last beat; cleared after tlast.
//    Lane i of a beat is frame byte offset+i. A capture register loads bytes 0..16+MCF_PARAMS_SIZE-1 as they pass.
//  Frame length at tlast = offset + popcount(tkeep); tkeep is contiguous from lane 0.
//  mcf_hit, evaluated on the accepted tlast beat using capture bytes from that beat too. All must hold:
//    cfg_rx_mcf_enable=1; eth_type == ETHERTYPE; length >= 14;
//    DA ok: cfg_rx_check_eth_dst=0, or DA == MCAST_DST, or DA == cfg_rx_eth_dst_ucast.
//  mcf_emit = mcf_hit & (length >= 16+MCF_PARAMS_SIZE) & ~s_axis_tuser[0].
//    A short or bad MCF is still marked bad in the stream but is not emitted.
//  Emit: fields load, mcf_valid=1 and stat_rx_mcf=1 in the cycle after the tlast beat is accepted (with m_axis tlast).
//    mcf_valid and the fields are held stable until mcf_valid & mcf_ready; mcf_valid then drops the next cycle.
//  Overrun: on mcf_emit while mcf_valid=1 and mcf_ready=0, the new MCF is discarded, the held one is kept,
//    and stat_rx_mcf_overrun pulses. If mcf_ready=1 in that same cycle, the new MCF is loaded (no overrun).
//  cfg_* inputs are sampled on the tlast beat; changes mid-frame take effect then.
//  Output stall: holding m_axis_tready=0 freezes the stream and offset; no data loss or duplication.
// TESTING (AXIS_DATA_WIDTH=64 unless noted)
//  1 64B IPv4 frame, EtherType 0x0800 -> bit-exact output, latency 1, tuser=0, mcf_valid stays 0.
//  2 64B PAUSE: DA 01:80:C2:00:00:01, EtherType 0x8808, opcode 0x0001, quanta 0xFFFF
//    -> tuser[0]=1 on tlast; mcf_opcode=16'h0001; mcf_params[15:0]=16'hFFFF; stat_rx_mcf 1 pulse.
//  3 Two PFC frames back-to-back (opcode 0x0101), mcf_ready=0 -> first held; stat_rx_mcf_overrun pulses once;
//    both frames are marked bad.
//  4 20B runt with 0x8808 -> marked bad, no mcf_valid. Same frame with input tuser[0]=1 -> no mcf_valid.
//  5 check_eth_dst=1, DA 02:00:00:00:00:01 != ucast -> passes unmarked. Set ucast to match -> emitted.
//  6 rst_n low mid-frame, then a PAUSE frame (repeat at width 512, random m_axis_tready)
//    -> correct parse, no stale fields.

Source files
------------

// File: rtl/mqnic_l2_ingress.sv
// mqnic_l2_ingress: layer-2 receive stage.
// Registers the RX AXI stream once and parses the first 16+MCF_PARAMS_SIZE bytes of each frame.
// Frames whose EtherType matches ETHERTYPE (and whose DA passes the optional check) are MAC
// control frames: their fields are presented on mcf_* and the frame is marked bad on tlast.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   s_axis_*                RX stream from the MAC (tdata/tkeep/tvalid/tready/tlast/tuser)
//   m_axis_*                RX stream to the datapath, one register stage
//   mcf_valid/mcf_ready     parsed control frame handshake
//   mcf_eth_dst/src/type    header fields, first wire byte in the MSBs
//   mcf_opcode/mcf_params   opcode {byte14,byte15}; params in lane order, [7:0] = byte16
//   cfg_rx_*                enable, station unicast DA, DA check enable (sampled on tlast)
//   stat_rx_mcf(_overrun)   one-cycle event pulses
module mqnic_l2_ingress #(
  parameter int unsigned AXIS_DATA_WIDTH = 256,
  parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int unsigned AXIS_USER_WIDTH = 1,
  parameter int unsigned MCF_PARAMS_SIZE = 18,
  parameter logic [15:0] ETHERTYPE       = 16'h8808,
  parameter logic [47:0] MCAST_DST       = 48'h0180C2000001
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  input  logic [AXIS_USER_WIDTH-1:0]   s_axis_tuser,

  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [AXIS_USER_WIDTH-1:0]   m_axis_tuser,

  output logic                         mcf_valid,
  input  logic                         mcf_ready,
  output logic [47:0]                  mcf_eth_dst,
  output logic [47:0]                  mcf_eth_src,
  output logic [15:0]                  mcf_eth_type,
  output logic [15:0]                  mcf_opcode,
  output logic [MCF_PARAMS_SIZE*8-1:0] mcf_params,

  input  logic                         cfg_rx_mcf_enable,
  input  logic [47:0]                  cfg_rx_eth_dst_ucast,
  input  logic                         cfg_rx_check_eth_dst,

  output logic                         stat_rx_mcf,
  output logic                         stat_rx_mcf_overrun
);

  localparam int unsigned HdrBytes = 16 + MCF_PARAMS_SIZE;
  localparam int unsigned OffW     = 16;
  localparam int unsigned LenW     = OffW + 1;
  // Largest offset that can still advance by a full beat without wrapping.
  localparam logic [OffW-1:0] OffSat = OffW'(2 ** OffW - 1 - AXIS_KEEP_WIDTH);

  logic                       accept;
  logic [OffW-1:0]            offset_q, offset_d;
  logic [HdrBytes*8-1:0]      cap_q, cap_d;
  logic [LenW-1:0]            keep_cnt, frame_len;
  logic [47:0]                da, sa;
  logic [15:0]                eth_type, opcode;
  logic [MCF_PARAMS_SIZE*8-1:0] params;
  logic                       da_ok, mcf_hit, mcf_emit, mcf_load, mcf_overrun;
  logic [AXIS_USER_WIDTH-1:0] user_d;

  logic [AXIS_DATA_WIDTH-1:0] tdata_q;
  logic [AXIS_KEEP_WIDTH-1:0] tkeep_q;
  logic                       tvalid_q, tlast_q;
  logic [AXIS_USER_WIDTH-1:0] tuser_q;

  logic                       mcf_valid_q, mcf_valid_d;
  logic [47:0]                dst_q, src_q;
  logic [15:0]                type_q, opcode_q;
  logic [MCF_PARAMS_SIZE*8-1:0] params_q;
  logic                       stat_mcf_q, stat_ovr_q;

  assign s_axis_tready = m_axis_tready | ~tvalid_q;
  assign accept        = s_axis_tvalid & s_axis_tready;

  // Offset is always a multiple of the beat size, so header byte j can only arrive in the beat
  // at offset (j / KEEP) * KEEP, on lane j % KEEP.
  always_comb begin
    cap_d = cap_q;
    for (int unsigned j = 0; j < HdrBytes; j++) begin
      if (offset_q == OffW'((j / AXIS_KEEP_WIDTH) * AXIS_KEEP_WIDTH) &&
          s_axis_tkeep[j % AXIS_KEEP_WIDTH]) begin
        cap_d[j*8 +: 8] = s_axis_tdata[(j % AXIS_KEEP_WIDTH)*8 +: 8];
      end
    end
  end

  always_comb begin
    keep_cnt = '0;
    for (int unsigned i = 0; i < AXIS_KEEP_WIDTH; i++) begin
      keep_cnt = keep_cnt + LenW'(s_axis_tkeep[i]);
    end
  end

  assign frame_len = LenW'(offset_q) + keep_cnt;

  // Header fields are taken from cap_d so the tlast beat's own bytes are included.
  always_comb begin
    da = '0;
    sa = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      da[47-8*k -: 8] = cap_d[k*8 +: 8];
      sa[47-8*k -: 8] = cap_d[(6+k)*8 +: 8];
    end
  end

  assign eth_type = {cap_d[12*8 +: 8], cap_d[13*8 +: 8]};
  assign opcode   = {cap_d[14*8 +: 8], cap_d[15*8 +: 8]};
  assign params   = cap_d[HdrBytes*8-1 -: MCF_PARAMS_SIZE*8];

  assign da_ok    = ~cfg_rx_check_eth_dst | (da == MCAST_DST) | (da == cfg_rx_eth_dst_ucast);
  assign mcf_hit  = cfg_rx_mcf_enable & (eth_type == ETHERTYPE) &
                    (frame_len >= LenW'(14)) & da_ok;
  assign mcf_emit = accept & s_axis_tlast & mcf_hit &
                    (frame_len >= LenW'(HdrBytes)) & ~s_axis_tuser[0];

  // A new frame replaces the held one only if the held one leaves in the same cycle.
  assign mcf_load    = mcf_emit & (~mcf_valid_q | mcf_ready);
  assign mcf_overrun = mcf_emit & mcf_valid_q & ~mcf_ready;

  always_comb begin
    mcf_valid_d = mcf_valid_q;
    if (mcf_load) begin
      mcf_valid_d = 1'b1;
    end else if (mcf_valid_q && mcf_ready) begin
      mcf_valid_d = 1'b0;
    end
  end

  always_comb begin
    offset_d = offset_q;
    if (accept) begin
      if (s_axis_tlast) begin
        offset_d = '0;
      end else if (offset_q <= OffSat) begin
        offset_d = offset_q + OffW'(AXIS_KEEP_WIDTH);
      end
    end
  end

  always_comb begin
    user_d    = s_axis_tuser;
    user_d[0] = s_axis_tuser[0] | (s_axis_tlast & mcf_hit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= '0;
      offset_q <= '0;
      cap_q    <= '0;
    end else begin
      offset_q <= offset_d;
      if (accept) begin
        tdata_q  <= s_axis_tdata;
        tkeep_q  <= s_axis_tkeep;
        tvalid_q <= 1'b1;
        tlast_q  <= s_axis_tlast;
        tuser_q  <= user_d;
        cap_q    <= cap_d;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcf_valid_q <= 1'b0;
      dst_q       <= '0;
      src_q       <= '0;
      type_q      <= '0;
      opcode_q    <= '0;
      params_q    <= '0;
      stat_mcf_q  <= 1'b0;
      stat_ovr_q  <= 1'b0;
    end else begin
      mcf_valid_q <= mcf_valid_d;
      stat_mcf_q  <= mcf_load;
      stat_ovr_q  <= mcf_overrun;
      if (mcf_load) begin
        dst_q    <= da;
        src_q    <= sa;
        type_q   <= eth_type;
        opcode_q <= opcode;
        params_q <= params;
      end
    end
  end

  assign m_axis_tdata        = tdata_q;
  assign m_axis_tkeep        = tkeep_q;
  assign m_axis_tvalid       = tvalid_q;
  assign m_axis_tlast        = tlast_q;
  assign m_axis_tuser        = tuser_q;
  assign mcf_valid           = mcf_valid_q;
  assign mcf_eth_dst         = dst_q;
  assign mcf_eth_src         = src_q;
  assign mcf_eth_type        = type_q;
  assign mcf_opcode          = opcode_q;
  assign mcf_params          = params_q;
  assign stat_rx_mcf         = stat_mcf_q;
  assign stat_rx_mcf_overrun = stat_ovr_q;

endmodule

// File: tb/tb_mqnic_l2_ingress.sv
// Bench for mqnic_l2_ingress: a 64-bit and a 512-bit instance driven with directed and random
// frames; expectations come from a byte-level frame model.
`timescale 1ns/1ps
module tb_mqnic_l2_ingress;

  localparam int unsigned HDR = 34;
  localparam int unsigned AK  = 8;
  localparam int unsigned BK  = 64;
  localparam int unsigned PW  = 144;
  localparam int unsigned MW  = 48 + 48 + 16 + 16 + PW;
  localparam logic [47:0] MCAST = 48'h0180C2000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cfg_en, cfg_chk;
  logic [47:0] cfg_ucast;

  logic [63:0]   a_s_tdata, a_m_tdata;
  logic [7:0]    a_s_tkeep, a_m_tkeep;
  logic          a_s_tvalid, a_s_tready, a_s_tlast, a_m_tvalid, a_m_tready, a_m_tlast;
  logic [0:0]    a_s_tuser, a_m_tuser;
  logic          a_mcf_valid, a_mcf_ready, a_stat, a_ovr;
  logic [47:0]   a_dst, a_src;
  logic [15:0]   a_type, a_op;
  logic [PW-1:0] a_params;

  logic [511:0]  b_s_tdata, b_m_tdata;
  logic [63:0]   b_s_tkeep, b_m_tkeep;
  logic          b_s_tvalid, b_s_tready, b_s_tlast, b_m_tvalid, b_m_tready, b_m_tlast;
  logic [0:0]    b_s_tuser, b_m_tuser;
  logic          b_mcf_valid, b_mcf_ready, b_stat, b_ovr;
  logic [47:0]   b_dst, b_src;
  logic [15:0]   b_type, b_op;
  logic [PW-1:0] b_params;

  mqnic_l2_ingress #(.AXIS_DATA_WIDTH(64), .MCF_PARAMS_SIZE(18)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(a_s_tdata), .s_axis_tkeep(a_s_tkeep), .s_axis_tvalid(a_s_tvalid),
    .s_axis_tready(a_s_tready), .s_axis_tlast(a_s_tlast), .s_axis_tuser(a_s_tuser),
    .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep), .m_axis_tvalid(a_m_tvalid),
    .m_axis_tready(a_m_tready), .m_axis_tlast(a_m_tlast), .m_axis_tuser(a_m_tuser),
    .mcf_valid(a_mcf_valid), .mcf_ready(a_mcf_ready), .mcf_eth_dst(a_dst), .mcf_eth_src(a_src),
    .mcf_eth_type(a_type), .mcf_opcode(a_op), .mcf_params(a_params),
    .cfg_rx_mcf_enable(cfg_en), .cfg_rx_eth_dst_ucast(cfg_ucast),
    .cfg_rx_check_eth_dst(cfg_chk), .stat_rx_mcf(a_stat), .stat_rx_mcf_overrun(a_ovr)
  );

  mqnic_l2_ingress #(.AXIS_DATA_WIDTH(512), .MCF_PARAMS_SIZE(18)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(b_s_tdata), .s_axis_tkeep(b_s_tkeep), .s_axis_tvalid(b_s_tvalid),
    .s_axis_tready(b_s_tready), .s_axis_tlast(b_s_tlast), .s_axis_tuser(b_s_tuser),
    .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid),
    .m_axis_tready(b_m_tready), .m_axis_tlast(b_m_tlast), .m_axis_tuser(b_m_tuser),
    .mcf_valid(b_mcf_valid), .mcf_ready(b_mcf_ready), .mcf_eth_dst(b_dst), .mcf_eth_src(b_src),
    .mcf_eth_type(b_type), .mcf_opcode(b_op), .mcf_params(b_params),
    .cfg_rx_mcf_enable(cfg_en), .cfg_rx_eth_dst_ucast(cfg_ucast),
    .cfg_rx_check_eth_dst(cfg_chk), .stat_rx_mcf(b_stat), .stat_rx_mcf_overrun(b_ovr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [575:0] got, input logic [575:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model state, index 0 = 64-bit instance, 1 = 512-bit instance.
  logic [7:0]    frm[$];
  int            exp_len   [2][$];
  logic [7:0]    exp_bytes [2][$];
  bit            exp_user  [2][$];
  logic [MW-1:0] exp_mcf   [2][$];
  logic [7:0]    cur       [2][$];
  int            cnt_st[2] = '{0, 0};
  int            cnt_ov[2] = '{0, 0};
  int            exp_st[2] = '{0, 0};
  int            exp_ov[2] = '{0, 0};
  bit            lat_pend[2] = '{0, 0};
  logic [511:0]  lat_data[2];
  bit            rand_rdy = 1'b0;

  function automatic bit model_hit(input int len);
    logic [47:0] da;
    logic [15:0] et;
    if (!cfg_en || len < 14) return 1'b0;
    for (int i = 0; i < 6; i++) da[47-8*i -: 8] = frm[i];
    et = {frm[12], frm[13]};
    return (et == 16'h8808) && (!cfg_chk || da == MCAST || da == cfg_ucast);
  endfunction

  function automatic logic [MW-1:0] model_mcf();
    logic [47:0]   da, sa;
    logic [PW-1:0] p;
    for (int i = 0; i < 6; i++) begin
      da[47-8*i -: 8] = frm[i];
      sa[47-8*i -: 8] = frm[6+i];
    end
    for (int j = 0; j < 18; j++) p[j*8 +: 8] = frm[16+j];
    return {da, sa, frm[12], frm[13], frm[14], frm[15], p};
  endfunction

  task automatic frame_done(input int n, input bit user);
    int L;
    int errs;
    check_val("frame_expected", 576'(exp_len[n].size() != 0), 576'(1));
    if (exp_len[n].size() == 0) begin
      cur[n].delete();
      return;
    end
    L = exp_len[n].pop_front();
    check_val(n ? "len_b" : "len_a", 576'(cur[n].size()), 576'(L));
    errs = 0;
    for (int i = 0; i < L; i++) begin
      logic [7:0] b;
      b = exp_bytes[n].pop_front();
      if (i >= cur[n].size() || cur[n][i] !== b) errs++;
    end
    check_val(n ? "data_b" : "data_a", 576'(errs), 576'(0));
    check_val(n ? "tuser_b" : "tuser_a", 576'(user), 576'(exp_user[n].pop_front()));
    cur[n].delete();
  endtask

  task automatic mon(input int n, input bit s_acc, input logic [511:0] s_data,
                     input bit m_hs, input bit m_v, input logic [511:0] m_data,
                     input logic [63:0] m_keep, input bit m_last, input bit m_user, input int kw,
                     input bit mcf_hs, input logic [MW-1:0] mcf, input bit st, input bit ov);
    if (!rst_n) begin
      cur[n].delete();
      lat_pend[n] = 1'b0;
      return;
    end
    // A beat accepted at the last edge must be on the output now.
    if (lat_pend[n]) check_val(n ? "lat_b" : "lat_a", 576'({m_v, m_data}),
                               576'({1'b1, lat_data[n]}));
    lat_pend[n] = s_acc;
    lat_data[n] = s_data;
    if (m_hs) begin
      for (int i = 0; i < kw; i++) if (m_keep[i]) cur[n].push_back(m_data[i*8 +: 8]);
      if (m_last) frame_done(n, m_user);
    end
    if (mcf_hs) begin
      check_val("mcf_expected", 576'(exp_mcf[n].size() != 0), 576'(1));
      if (exp_mcf[n].size() != 0)
        check_val(n ? "mcf_fields_b" : "mcf_fields_a", 576'(mcf), 576'(exp_mcf[n].pop_front()));
    end
    if (st) cnt_st[n]++;
    if (ov) cnt_ov[n]++;
  endtask

  always @(negedge clk) begin
    mon(0, a_s_tvalid & a_s_tready, 512'(a_s_tdata), a_m_tvalid & a_m_tready, a_m_tvalid,
        512'(a_m_tdata), 64'(a_m_tkeep), a_m_tlast, a_m_tuser[0], AK, a_mcf_valid & a_mcf_ready,
        {a_dst, a_src, a_type, a_op, a_params}, a_stat, a_ovr);
    mon(1, b_s_tvalid & b_s_tready, b_s_tdata, b_m_tvalid & b_m_tready, b_m_tvalid,
        b_m_tdata, b_m_tkeep, b_m_tlast, b_m_tuser[0], BK, b_mcf_valid & b_mcf_ready,
        {b_dst, b_src, b_type, b_op, b_params}, b_stat, b_ovr);
  end

  initial begin
    a_m_tready = 1'b1;
    b_m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      a_m_tready = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
      b_m_tready = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input int n, input bit v, input logic [511:0] d, input logic [63:0] k,
                       input bit last, input bit u);
    if (n == 0) begin
      a_s_tvalid = v; a_s_tdata = d[63:0]; a_s_tkeep = k[7:0]; a_s_tlast = last; a_s_tuser = u;
    end else begin
      b_s_tvalid = v; b_s_tdata = d; b_s_tkeep = k; b_s_tlast = last; b_s_tuser = u;
    end
  endtask

  task automatic wait_accept(input int n);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (n == 0 ? a_s_tready : b_s_tready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    $display("FAIL accept_timeout: instance %0d never ready", n);
    $fatal(1);
  endtask

  task automatic build_frame(input logic [47:0] da, input logic [47:0] sa,
                             input logic [15:0] et, input logic [15:0] op, input int len);
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(sa[47-8*i -: 8]);
    frm.push_back(et[15:8]); frm.push_back(et[7:0]);
    frm.push_back(op[15:8]); frm.push_back(op[7:0]);
    while (frm.size() < len) frm.push_back(8'($urandom));
    while (frm.size() > len) void'(frm.pop_back());
  endtask

  // abort_after >= 0 stops after that many beats and records nothing.
  task automatic send_frame(input int n, input bit user, input bit push_mcf, input int abort_after);
    int kw;
    int len;
    int beat;
    logic [511:0] d;
    logic [63:0]  k;
    bit last, hit, emit;
    kw   = n ? BK : AK;
    len  = frm.size();
    beat = 0;
    for (int off = 0; off < len; off += kw) begin
      if (abort_after >= 0 && beat == abort_after) break;
      d = '0;
      k = '0;
      for (int i = 0; i < kw; i++) begin
        if (off + i < len) begin
          d[i*8 +: 8] = frm[off+i];
          k[i] = 1'b1;
        end
      end
      last = (off + kw >= len);
      drive(n, 1'b1, d, k, last, last & user);
      wait_accept(n);
      beat++;
    end
    drive(n, 1'b0, '0, '0, 1'b0, 1'b0);
    if (abort_after >= 0) return;
    hit  = model_hit(len);
    emit = hit && (len >= HDR) && !user;
    exp_len[n].push_back(len);
    foreach (frm[i]) exp_bytes[n].push_back(frm[i]);
    exp_user[n].push_back(user | hit);
    if (emit) begin
      if (push_mcf) begin
        exp_mcf[n].push_back(model_mcf());
        exp_st[n]++;
      end else begin
        exp_ov[n]++;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_len[0].size() + exp_len[1].size() + exp_mcf[0].size() + exp_mcf[1].size()) != 0
           && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check_val("drain", 576'(exp_len[0].size() + exp_len[1].size() + exp_mcf[0].size() +
                            exp_mcf[1].size()), 576'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
    for (int n = 0; n < 2; n++) begin
      check_val({tag, "_stat_mcf"}, 576'(cnt_st[n]), 576'(exp_st[n]));
      check_val({tag, "_stat_ovr"}, 576'(cnt_ov[n]), 576'(exp_ov[n]));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_a", 576'({a_m_tvalid, a_mcf_valid, a_stat, a_ovr, a_dst, a_src, a_type,
                             a_op, a_params}), '0);
    check_val("rst_b", 576'({b_m_tvalid, b_mcf_valid, b_stat, b_ovr, b_dst, b_src, b_type,
                             b_op, b_params}), '0);
    rst_n = 1'b1;
  endtask

  task automatic wait_mcf_valid();
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (a_mcf_valid) break;
    end
  endtask

  initial begin
    logic [MW-1:0] held;
    logic [47:0]   da;
    rst_n       = 1'b0;
    cfg_en      = 1'b1;
    cfg_chk     = 1'b0;
    cfg_ucast   = 48'h020000000099;
    a_mcf_ready = 1'b1;
    b_mcf_ready = 1'b1;
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
    do_reset();

    // IPv4 frame: plain pass-through.
    build_frame(48'h001122334455, 48'h02AABBCCDDEE, 16'h0800, 16'h4500, 64);
    send_frame(0, 1'b0, 1'b1, -1);
    drain();
    check_val("ipv4_mcf_valid", 576'(a_mcf_valid), 576'(0));
    check_stats("ipv4");

    // PAUSE, held until the consumer takes it.
    a_mcf_ready = 1'b0;
    build_frame(MCAST, 48'h02AABBCCDDEE, 16'h8808, 16'h0001, 64);
    frm[16] = 8'hFF;
    frm[17] = 8'hFF;
    send_frame(0, 1'b0, 1'b1, -1);
    wait_mcf_valid();
    check_val("pause_valid", 576'(a_mcf_valid), 576'(1));
    check_val("pause_opcode", 576'(a_op), 576'(16'h0001));
    check_val("pause_quanta", 576'(a_params[15:0]), 576'(16'hFFFF));
    a_mcf_ready = 1'b1;
    drain();
    check_stats("pause");

    // Two PFC frames back to back with the consumer stalled.
    a_mcf_ready = 1'b0;
    build_frame(MCAST, 48'h02AABBCCDDEE, 16'h8808, 16'h0101, 64);
    send_frame(0, 1'b0, 1'b1, -1);
    build_frame(MCAST, 48'h02AABBCCDD01, 16'h8808, 16'h0101, 64);
    send_frame(0, 1'b0, 1'b0, -1);
    repeat (5) @(posedge clk);
    #1;
    check_val("pfc_held_valid", 576'(a_mcf_valid), 576'(1));
    check_val("pfc_held_count", 576'(exp_mcf[0].size()), 576'(1));
    held = (exp_mcf[0].size() != 0) ? exp_mcf[0][0] : '0;
    check_val("pfc_held_fields", 576'({a_dst, a_src, a_type, a_op, a_params}), 576'(held));
    a_mcf_ready = 1'b1;
    drain();
    check_stats("pfc");

    // Runt control frame, then bad-marked frames from the MAC.
    build_frame(MCAST, 48'h02AABBCCDDEE, 16'h8808, 16'h0001, 20);
    send_frame(0, 1'b0, 1'b1, -1);
    send_frame(0, 1'b1, 1'b1, -1);
    build_frame(MCAST, 48'h02AABBCCDDEE, 16'h8808, 16'h0001, 64);
    send_frame(0, 1'b1, 1'b1, -1);
    drain();
    check_val("runt_mcf_valid", 576'(a_mcf_valid), 576'(0));
    check_stats("runt");

    // Destination check against the station unicast address.
    cfg_chk = 1'b1;
    build_frame(48'h020000000001, 48'h02AABBCCDDEE, 16'h8808, 16'h0001, 64);
    send_frame(0, 1'b0, 1'b1, -1);
    cfg_ucast = 48'h020000000001;
    send_frame(0, 1'b0, 1'b1, -1);
    drain();
    check_stats("ucast");
    cfg_chk   = 1'b0;
    cfg_ucast = 48'h020000000099;

    // Random frames with random output backpressure on both widths.
    rand_rdy = 1'b1;
    for (int f = 0; f < 60; f++) begin
      cfg_en  = ($urandom_range(3) != 0);
      cfg_chk = $urandom_range(1);
      case ($urandom_range(2))
        0:       da = MCAST;
        1:       da = cfg_ucast;
        default: da = 48'({$urandom(), $urandom()});
      endcase
      build_frame(da, 48'h02123456789A, $urandom_range(1) ? 16'h8808 : 16'h0800,
                  16'($urandom), $urandom_range(120, 8));
      send_frame(f % 3 == 2 ? 1 : 0, ($urandom_range(7) == 0), 1'b1, -1);
    end
    drain();
    check_stats("random");
    cfg_en  = 1'b1;
    cfg_chk = 1'b0;

    // Reset in the middle of a frame, then a clean PAUSE, on each width.
    for (int n = 0; n < 2; n++) begin
      build_frame(MCAST, 48'h02AABBCCDDEE, 16'h8808, 16'h0001, 200);
      send_frame(n, 1'b0, 1'b1, 2);
      do_reset();
      build_frame(MCAST, 48'h0255AA55AA55, 16'h8808, 16'h0001, 64);
      frm[16] = 8'h12;
      frm[17] = 8'h34;
      send_frame(n, 1'b0, 1'b1, -1);
      drain();
      check_stats(n ? "rst_mid_b" : "rst_mid_a");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
